// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: sequences each instruction through fetch,
// decode, execute, memory and writeback, and owns the NZCV flag register.
module multicycle_controller #(
    parameter int unsigned MEM_LAT   = 1,
    parameter logic [3:0]  FLAG_INIT = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q;
    logic [3:0] cmd_q;
    logic       sl_q;
    logic [3:0] rd_q;
    logic [1:0] op_q;

    logic       last_wait;
    logic       pc_write, ir_write, reg_write, mem_write;
    logic [2:0] alu_dec;
    logic       no_write, s_eff, arith;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = cf;
            4'b0011: cond_eval = ~cf;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = cf & ~z;
            4'b1001: cond_eval = ~cf | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            default: cond_eval = 1'b1;
        endcase
    endfunction

    assign last_wait = (wait_q == LAST_WAIT);

    // ALU decode works on the command latched in Decode.
    always_comb begin
        alu_dec  = 3'b000;
        no_write = 1'b0;
        s_eff    = sl_q;
        arith    = 1'b0;
        case (cmd_q)
            4'b0100: arith = 1'b1;
            4'b0010: begin alu_dec = 3'b001; arith = 1'b1; end
            4'b0000: alu_dec = 3'b010;
            4'b1100: alu_dec = 3'b011;
            4'b1010: begin alu_dec = 3'b001; arith = 1'b1; no_write = 1'b1; s_eff = 1'b1; end
            default: no_write = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        case (state_q)
            S_FETCH:    if (last_wait) state_d = S_DECODE;   else wait_d = wait_q + 4'd1;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = sl_q ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (last_wait) state_d = S_MEMWB;    else wait_d = wait_q + 4'd1;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (last_wait) state_d = S_FETCH;    else wait_d = wait_q + 4'd1;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && condex_q) begin
            if (s_eff)         flags_d[3:2] = ALUFlags[3:2];
            if (s_eff & arith) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_q   <= 4'd0;
            flags_q  <= FLAG_INIT;
            condex_q <= 1'b0;
            cmd_q    <= 4'd0;
            sl_q     <= 1'b0;
            rd_q     <= 4'd0;
            op_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            flags_q <= flags_d;
            if (state_q == S_DECODE) begin
                condex_q <= cond_eval(Cond, flags_q);
                cmd_q    <= Funct[4:1];
                sl_q     <= Funct[0];
                rd_q     <= Rd;
                op_q     <= Op;
            end
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = last_wait;
                pc_write  = last_wait;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_write  = condex_q;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = condex_q;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                if (rd_q == 4'd15) pc_write  = condex_q;
                else               reg_write = condex_q;
            end
            S_EXECR: ALUControl = alu_dec;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            S_ALUWB: begin
                if (rd_q == 4'd15) pc_write  = condex_q;
                else               reg_write = condex_q & ~no_write;
            end
            default: ;
        endcase
    end

    // Reset is asynchronous, so the enables are gated directly to stay quiet while it is held.
    assign PCWrite  = pc_write  & ~reset;
    assign IRWrite  = ir_write  & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign MemWrite = mem_write & ~reset;

    assign ImmSrc = op_q;
    assign RegSrc = {op_q == 2'b01, op_q == 2'b10};
    assign Flags  = flags_q;
    assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised scoreboard bench for multicycle_controller: an instruction-level model
// expands each instruction into its expected per-cycle control trace.
module tb_multicycle_controller;

    localparam int         LAT = 3;
    localparam logic [3:0] FI  = 4'b1010;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                   MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags, State;

    multicycle_controller #(.MEM_LAT(LAT), .FLAG_INIT(FI)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .State(State)
    );

    always #5 clk = ~clk;

    // care bits: 0 AdrSrc, 1 ResultSrc, 2 ALUSrcA, 3 ALUSrcB, 4 ALUControl, 5 ImmSrc/RegSrc
    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mw;
        logic       adr;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [1:0] imm, rsrc;
        logic [3:0] flags;
        logic [5:0] care;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [3:0] mflags;
    exp_t       e;
    bit         ok;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL underflow cycle %0d: DUT state=%0d with no expected entry", cyc, State);
            end else begin
                e  = sb.pop_front();
                ok = !(State !== e.st || PCWrite !== e.pcw || IRWrite !== e.irw ||
                       RegWrite !== e.rw || MemWrite !== e.mw || Flags !== e.flags);
                if (e.care[0] && AdrSrc !== e.adr)     ok = 1'b0;
                if (e.care[1] && ResultSrc !== e.res)  ok = 1'b0;
                if (e.care[2] && ALUSrcA !== e.srca)   ok = 1'b0;
                if (e.care[3] && ALUSrcB !== e.srcb)   ok = 1'b0;
                if (e.care[4] && ALUControl !== e.alu) ok = 1'b0;
                if (e.care[5] && (ImmSrc !== e.imm || RegSrc !== e.rsrc)) ok = 1'b0;
                if (!ok) begin
                    failures++;
                    $display("FAIL ctrl cycle %0d: got st=%0d pc/ir/rw/mw=%b%b%b%b fl=%b adr=%b res=%b a=%b b=%b alu=%b imm=%b rs=%b | exp st=%0d pc/ir/rw/mw=%b%b%b%b fl=%b adr=%b res=%b a=%b b=%b alu=%b imm=%b rs=%b care=%b",
                             cyc, State, PCWrite, IRWrite, RegWrite, MemWrite, Flags, AdrSrc, ResultSrc,
                             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc,
                             e.st, e.pcw, e.irw, e.rw, e.mw, e.flags, e.adr, e.res, e.srca, e.srcb,
                             e.alu, e.imm, e.rsrc, e.care);
                end
            end
            cyc++;
        end
    end

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cf = f[1], v = f[0];
        case (c)
            0: return z;            1: return !z;
            2: return cf;           3: return !cf;
            4: return n;            5: return !n;
            6: return v;            7: return !v;
            8: return cf && !z;     9: return !cf || z;
            10: return n == v;      11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic reset_cycles(input int n);
        exp_t r;
        for (int i = 0; i < n; i++) begin
            reset    = 1'b1;
            ALUFlags = 4'($urandom);
            r        = '0;
            r.st     = 4'(FETCH);
            r.flags  = FI;
            sb.push_back(r);
            @(posedge clk); #1;
        end
        mflags = FI;
        reset  = 1'b0;
    endtask

    // abort_at: -1 none, -2 random cycle, otherwise the cycle index where reset strikes.
    task automatic run_instr(input logic [31:0] ins, input bit fix, input logic [3:0] fixf,
                             input int abort_at);
        logic [3:0] cnd  = ins[31:28];
        logic [1:0] op   = ins[27:26];
        logic [5:0] fn   = ins[25:20];
        logic [3:0] rd   = ins[15:12];
        logic [3:0] cmd  = fn[4:1];
        int         seq[$];
        logic [3:0] af[$];
        bit         pass, nowr, sflag, cv;
        logic [2:0] aluc;
        int         n, ab;
        exp_t       r;

        for (int i = 0; i < LAT; i++) seq.push_back(FETCH);
        seq.push_back(DECODE);
        case (op)
            2'b00: begin seq.push_back(fn[5] ? EXECI : EXECR); seq.push_back(ALUWB); end
            2'b01: begin
                seq.push_back(MEMADR);
                if (fn[0]) begin
                    for (int i = 0; i < LAT; i++) seq.push_back(MEMREAD);
                    seq.push_back(MEMWB);
                end else begin
                    for (int i = 0; i < LAT; i++) seq.push_back(MEMWRITE);
                end
            end
            2'b10: seq.push_back(BRANCH);
            default: ;
        endcase

        sflag = fn[0]; nowr = 1'b0; cv = 1'b0; aluc = 3'b000;
        case (cmd)
            4'b0100: cv = 1'b1;
            4'b0010: begin aluc = 3'b001; cv = 1'b1; end
            4'b0000: aluc = 3'b010;
            4'b1100: aluc = 3'b011;
            4'b1010: begin aluc = 3'b001; cv = 1'b1; nowr = 1'b1; sflag = 1'b1; end
            default: nowr = 1'b1;
        endcase
        pass = cond_ok(cnd, mflags);

        ab = abort_at;
        if (ab == -2) ab = int'($urandom_range(0, seq.size() - 1));
        n = (ab >= 0 && ab < seq.size()) ? ab : seq.size();

        for (int k = 0; k < n; k++) begin
            af.push_back(fix ? fixf : 4'($urandom));
            r       = '0;
            r.st    = 4'(seq[k]);
            r.flags = mflags;
            r.imm   = op;
            r.rsrc  = {op == 2'b01, op == 2'b10};
            if (k > LAT) r.care[5] = 1'b1;
            case (seq[k])
                FETCH: begin
                    r.care[4:0] = 5'b11111;
                    r.srca = 1'b1; r.srcb = 2'b10; r.res = 2'b10;
                    r.pcw = (k == LAT - 1); r.irw = (k == LAT - 1);
                end
                DECODE: begin
                    r.care[4:1] = 4'b1111;
                    r.srca = 1'b1; r.srcb = 2'b10; r.res = 2'b10;
                end
                MEMADR: begin r.care[4:2] = 3'b111; r.srcb = 2'b01; end
                BRANCH: begin
                    r.care[4:1] = 4'b1111;
                    r.srcb = 2'b01; r.res = 2'b10; r.pcw = pass;
                end
                MEMREAD:  begin r.care[1:0] = 2'b11; r.adr = 1'b1; end
                MEMWRITE: begin r.care[0] = 1'b1; r.adr = 1'b1; r.mw = pass; end
                MEMWB: begin
                    r.care[1] = 1'b1; r.res = 2'b01;
                    if (rd == 4'd15) r.pcw = pass; else r.rw = pass;
                end
                EXECR, EXECI: begin
                    r.care[4:2] = 3'b111;
                    r.srcb = (seq[k] == EXECI) ? 2'b01 : 2'b00;
                    r.alu  = aluc;
                end
                ALUWB: begin
                    r.care[1] = 1'b1;
                    if (rd == 4'd15) r.pcw = pass; else r.rw = pass && !nowr;
                end
                default: ;
            endcase
            sb.push_back(r);
            if ((seq[k] == EXECR || seq[k] == EXECI) && pass && sflag) begin
                mflags[3:2] = af[k][3:2];
                if (cv) mflags[1:0] = af[k][1:0];
            end
        end

        for (int k = 0; k < n; k++) begin
            if (k <= LAT) begin
                Cond = cnd; Op = op; Funct = fn; Rd = rd;
            end else begin
                Cond = 4'($urandom); Op = 2'($urandom); Funct = 6'($urandom); Rd = 4'($urandom);
            end
            ALUFlags = af[k];
            @(posedge clk); #1;
        end
        if (n < seq.size()) reset_cycles(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; Cond = '0; Op = '0; Funct = '0; Rd = '0; ALUFlags = '0;
        mflags = FI;
        @(posedge clk); #1;
        mon_en = 1'b1;
        reset_cycles(2);

        run_instr(32'hE0821003, 1'b1, 4'b0000, -1);   // ADD R1,R2,R3
        run_instr(32'hE0512003, 1'b1, 4'b0100, -1);   // SUBS, Z=1
        run_instr(32'h0A000000, 1'b0, 4'b0000, -1);   // BEQ taken
        run_instr(32'hE0512003, 1'b1, 4'b0000, -1);   // SUBS, Z=0
        run_instr(32'h0A000000, 1'b0, 4'b0000, -1);   // BEQ not taken
        run_instr(32'hE5921004, 1'b0, 4'b0000, -1);   // LDR
        run_instr(32'hE0512003, 1'b1, 4'b0100, -1);   // SUBS, Z=1
        run_instr(32'h15821004, 1'b0, 4'b0000, -1);   // STRNE suppressed
        run_instr(32'hE1510002, 1'b0, 4'b0000, -1);   // CMP R1,R2
        run_instr(32'hE082F003, 1'b0, 4'b0000, -1);   // ADD PC,R2,R3
        run_instr(32'hE5821004, 1'b0, 4'b0000, LAT + 3); // STR, reset in MemWrite cycle 2
        run_instr(32'hE0821003, 1'b0, 4'b0000, -1);

        for (int i = 0; i < 150; i++) begin
            run_instr($urandom, 1'b0, 4'b0000, ($urandom_range(0, 19) == 0) ? -2 : -1);
        end

        mon_en = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
